// File: rtl/pc_predict_unit_pkg.sv
// Shared definitions for the fetch PC predictor: branch condition encodings,
// flag bit positions inside the {Z,V,N} vector, and 2-bit saturating counter
// states with helper functions.
package pc_predict_unit_pkg;

    // Branch condition codes
    localparam logic [2:0] CC_NE     = 3'b000;  // !Z
    localparam logic [2:0] CC_EQ     = 3'b001;  // Z
    localparam logic [2:0] CC_GT     = 3'b010;  // !Z & !N
    localparam logic [2:0] CC_LT     = 3'b011;  // N
    localparam logic [2:0] CC_GE     = 3'b100;  // Z | !N
    localparam logic [2:0] CC_LE     = 3'b101;  // Z | N
    localparam logic [2:0] CC_VS     = 3'b110;  // V
    localparam logic [2:0] CC_UNCOND = 3'b111;  // always

    // Bit positions in the flags vector {Z,V,N}
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Saturating direction counter; bit 1 is the taken prediction
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == ST) ? ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/pc_predict_unit_cond.sv
// branch_cond_eval: combinational branch condition evaluation.
// Ports:
//   i_ccc   - 3-bit condition code
//   i_flags - {Z,V,N} flags from execute
//   o_taken - 1 when the condition holds
module branch_cond_eval
    import pc_predict_unit_pkg::*;
(
    input  logic [2:0] i_ccc,
    input  logic [2:0] i_flags,
    output logic       o_taken
);
    logic w_z, w_v, w_n;

    assign w_z = i_flags[FLAG_Z];
    assign w_v = i_flags[FLAG_V];
    assign w_n = i_flags[FLAG_N];

    always_comb begin
        o_taken = 1'b0;
        case (i_ccc)
            CC_NE:     o_taken = ~w_z;
            CC_EQ:     o_taken = w_z;
            CC_GT:     o_taken = ~w_z & ~w_n;
            CC_LT:     o_taken = w_n;
            CC_GE:     o_taken = w_z | ~w_n;
            CC_LE:     o_taken = w_z | w_n;
            CC_VS:     o_taken = w_v;
            CC_UNCOND: o_taken = 1'b1;
            default:   o_taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/pc_predict_unit.sv
// pc_predict_unit: architectural fetch PC register with next-PC prediction
// from a direct-mapped BTB (2-bit saturating counters). Resolves B/BR
// branches from execute, trains the BTB, and redirects fetch on mispredict.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   stall, halt       - hold PC for one cycle / freeze PC until reset
//   pc                - current fetch address
//   pred_taken        - BTB prediction for the instruction at pc
//   pred_target       - predicted next PC (pc+2 when not taken)
//   ex_*              - resolving branch from execute with its carried prediction
//   mispredict        - registered 1-cycle pulse, coincident with redirected pc
//   resolved_pc       - correct next PC of the EX branch (combinational)
module pc_predict_unit
    import pc_predict_unit_pkg::*;
#(
    parameter int              ADDR_W    = 16,
    parameter int              BTB_DEPTH = 8,
    parameter int              IMM_W     = 9,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              ex_valid,
    input  logic              ex_br,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic [2:0]        ex_ccc,
    input  logic [2:0]        ex_flags,
    input  logic [IMM_W-1:0]  ex_imm,
    input  logic [ADDR_W-1:0] ex_rs,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] resolved_pc
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - 1;

    // BTB storage
    logic              r_valid  [BTB_DEPTH];
    logic [TAG_W-1:0]  r_tag    [BTB_DEPTH];
    logic [ADDR_W-1:0] r_target [BTB_DEPTH];
    logic [1:0]        r_ctr    [BTB_DEPTH];

    logic [ADDR_W-1:0] r_pc;
    logic              r_halted;
    logic              r_mispredict;

    // ---------------- fetch-side lookup ----------------
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic [ADDR_W-1:0] w_pc_seq;

    assign w_idx    = r_pc[IDX_W:1];
    assign w_tag    = r_pc[ADDR_W-1:IDX_W+1];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_pc_seq = r_pc + ADDR_W'(2);

    assign pc          = r_pc;
    assign pred_taken  = w_hit & r_ctr[w_idx][1];
    assign pred_target = pred_taken ? r_target[w_idx] : w_pc_seq;

    // ---------------- execute-side resolution ----------------
    logic              w_taken;
    logic [IDX_W-1:0]  w_ex_idx;
    logic [TAG_W-1:0]  w_ex_tag;
    logic              w_ex_hit;
    logic [ADDR_W-1:0] w_ex_seq;
    logic [ADDR_W-1:0] w_imm_ext;
    logic [ADDR_W-1:0] w_ex_btgt;
    logic [ADDR_W-1:0] w_actual;
    logic              w_mispredict;
    logic              w_unused_pred_taken;

    branch_cond_eval u_cond (
        .i_ccc   (ex_ccc),
        .i_flags (ex_flags),
        .o_taken (w_taken)
    );

    assign w_ex_idx  = ex_pc[IDX_W:1];
    assign w_ex_tag  = ex_pc[ADDR_W-1:IDX_W+1];
    assign w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_imm_ext = {{(ADDR_W-IMM_W){ex_imm[IMM_W-1]}}, ex_imm};
    assign w_ex_seq  = ex_pc + ADDR_W'(2);
    assign w_ex_btgt = w_ex_seq + (w_imm_ext << 1);
    assign w_actual  = w_taken ? (ex_br ? ex_rs : w_ex_btgt) : w_ex_seq;

    // Comparing the full predicted next PC catches both a wrong direction
    // and a right direction with a stale target.
    assign w_mispredict = ex_valid & (ex_pred_target != w_actual);

    assign resolved_pc = w_actual;
    assign mispredict  = r_mispredict;

    // The carried direction bit is implied by the carried target.
    assign w_unused_pred_taken = ex_pred_taken;

    // ---------------- PC register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_halted     <= 1'b0;
            r_mispredict <= 1'b0;
        end else begin
            r_mispredict <= w_mispredict;
            r_halted     <= r_halted | halt;
            if (w_mispredict)
                r_pc <= w_actual;
            else if (stall | halt | r_halted)
                r_pc <= r_pc;
            else
                r_pc <= pred_target;
        end
    end

    // ---------------- BTB training ----------------
    // Written at the edge, so a lookup of the same index in the same cycle
    // still sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= WNT;
            end
        end else if (ex_valid) begin
            if (w_taken) begin
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= w_actual;
                r_ctr[w_ex_idx]    <= w_ex_hit ? ctr_inc(r_ctr[w_ex_idx]) : WT;
            end else if (w_ex_hit) begin
                r_ctr[w_ex_idx]    <= ctr_dec(r_ctr[w_ex_idx]);
            end
        end
    end

endmodule

// File: tb/tb_pc_predict_unit.sv
module tb_pc_predict_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, halt = 1'b0;
    logic [15:0] pc, pred_target, resolved_pc;
    logic        pred_taken, mispredict;
    logic        ex_valid = 1'b0, ex_br = 1'b0, ex_pred_taken = 1'b0;
    logic [15:0] ex_pc = '0, ex_rs = '0, ex_pred_target = '0;
    logic [2:0]  ex_ccc = '0, ex_flags = '0;
    logic [8:0]  ex_imm = '0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct { logic [15:0] pc; logic mp; } exp_t;
    exp_t exp_q[$];
    exp_t e;

    pc_predict_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt),
        .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_br(ex_br), .ex_pc(ex_pc), .ex_ccc(ex_ccc),
        .ex_flags(ex_flags), .ex_imm(ex_imm), .ex_rs(ex_rs),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .resolved_pc(resolved_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic br, input logic [15:0] epc, input logic [2:0] ccc,
                            input logic [2:0] flags, input logic [8:0] imm, input logic [15:0] rs,
                            input logic pt, input logic [15:0] ptgt);
        ex_valid = 1'b1; ex_br = br; ex_pc = epc; ex_ccc = ccc; ex_flags = flags;
        ex_imm = imm; ex_rs = rs; ex_pred_taken = pt; ex_pred_target = ptgt;
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0;
    endtask

    // Unconditional BR from src to dst, carried prediction = not taken
    task automatic redirect(input logic [15:0] src, input logic [15:0] dst);
        drive_ex(1'b1, src, 3'b111, 3'b000, 9'h000, dst, 1'b0, src + 16'd2);
        tick();
        clear_ex();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (pc !== 16'h0000 || pred_taken !== 1'b0 || mispredict !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: pc=%h pt=%b mp=%b, expected 0000/0/0", pc, pred_taken, mispredict);
        end
        for (int i = 1; i < 4; i++) exp_q.push_back('{16'(2 * i), 1'b0});
        for (int i = 1; i < 4; i++) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (pc !== e.pc || mispredict !== e.mp || pred_taken !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_seq%0d: pc=%h mp=%b pt=%b, expected pc=%h mp=%b pt=0",
                         i, pc, mispredict, pred_taken, e.pc, e.mp);
            end
        end
    endtask

    task automatic test_b_taken();
        drive_ex(1'b0, 16'h0004, 3'b111, 3'b000, 9'd3, 16'h0000, 1'b0, 16'h0006);
        #1;
        n_checks++;
        if (resolved_pc !== 16'h000C) begin
            n_errors++;
            $display("FAIL b_resolved_pc: got %h expected 000c", resolved_pc);
        end
        exp_q.push_back('{16'h000C, 1'b1});
        exp_q.push_back('{16'h000E, 1'b0});
        tick(); clear_ex();
        e = exp_q.pop_front();
        n_checks++;
        if (pc !== e.pc || mispredict !== e.mp) begin
            n_errors++;
            $display("FAIL b_redirect: pc=%h mp=%b expected pc=%h mp=%b", pc, mispredict, e.pc, e.mp);
        end
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (pc !== e.pc || mispredict !== e.mp) begin
            n_errors++;
            $display("FAIL b_pulse_end: pc=%h mp=%b expected pc=%h mp=%b", pc, mispredict, e.pc, e.mp);
        end
        exp_q.push_back('{16'h0004, 1'b1});
        redirect(16'h0100, 16'h0004);
        e = exp_q.pop_front();
        n_checks++;
        if (pc !== e.pc || pred_taken !== 1'b1 || pred_target !== 16'h000C) begin
            n_errors++;
            $display("FAIL b_second_pass: pc=%h pt=%b tgt=%h expected pc=%h pt=1 tgt=000c",
                     pc, pred_taken, pred_target, e.pc);
        end
        drive_ex(1'b0, 16'h0004, 3'b111, 3'b000, 9'd3, 16'h0000, 1'b1, 16'h000C);
        exp_q.push_back('{16'h000C, 1'b0});
        tick(); clear_ex();
        e = exp_q.pop_front();
        n_checks++;
        if (pc !== e.pc || mispredict !== e.mp) begin
            n_errors++;
            $display("FAIL b_correct_pred: pc=%h mp=%b expected pc=%h mp=%b", pc, mispredict, e.pc, e.mp);
        end
    endtask

    task automatic test_loop_ctr();
        // Train BEQ at 0x0008 (target 0x0006) to strongly taken
        drive_ex(1'b0, 16'h0008, 3'b001, 3'b100, 9'h1FE, 16'h0000, 1'b0, 16'h000A);
        exp_q.push_back('{16'h0006, 1'b1});
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (pc !== e.pc || mispredict !== e.mp) begin
            n_errors++;
            $display("FAIL loop_train1: pc=%h mp=%b expected pc=%h mp=%b", pc, mispredict, e.pc, e.mp);
        end
        drive_ex(1'b0, 16'h0008, 3'b001, 3'b100, 9'h1FE, 16'h0000, 1'b1, 16'h0006);
        exp_q.push_back('{16'h0008, 1'b0});
        tick(); clear_ex();
        e = exp_q.pop_front();
        n_checks++;
        if (pc !== e.pc || mispredict !== e.mp || pred_taken !== 1'b1 || pred_target !== 16'h0006) begin
            n_errors++;
            $display("FAIL loop_train2: pc=%h mp=%b pt=%b tgt=%h expected pc=%h mp=%b pt=1 tgt=0006",
                     pc, mispredict, pred_taken, pred_target, e.pc, e.mp);
        end
        // Loop exit: Z=0, not taken against a taken prediction
        drive_ex(1'b0, 16'h0008, 3'b001, 3'b000, 9'h1FE, 16'h0000, 1'b1, 16'h0006);
        exp_q.push_back('{16'h000A, 1'b1});
        tick(); clear_ex();
        e = exp_q.pop_front();
        n_checks++;
        if (pc !== e.pc || mispredict !== e.mp) begin
            n_errors++;
            $display("FAIL loop_exit: pc=%h mp=%b expected pc=%h mp=%b", pc, mispredict, e.pc, e.mp);
        end
        redirect(16'h00FE, 16'h0008);
        n_checks++;
        if (pc !== 16'h0008 || pred_taken !== 1'b1) begin
            n_errors++;
            $display("FAIL loop_ctr_weak_taken: pc=%h pt=%b expected pc=0008 pt=1", pc, pred_taken);
        end
        drive_ex(1'b0, 16'h0008, 3'b001, 3'b000, 9'h1FE, 16'h0000, 1'b1, 16'h0006);
        tick(); clear_ex();
        redirect(16'h00FE, 16'h0008);
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 16'h000A) begin
            n_errors++;
            $display("FAIL loop_ctr_weak_nt: pt=%b tgt=%h expected pt=0 tgt=000a", pred_taken, pred_target);
        end
    endtask

    task automatic test_br_stale();
        drive_ex(1'b1, 16'h0020, 3'b111, 3'b000, 9'h000, 16'h1000, 1'b0, 16'h0022);
        exp_q.push_back('{16'h1000, 1'b1});
        tick(); clear_ex();
        e = exp_q.pop_front();
        n_checks++;
        if (pc !== e.pc || mispredict !== e.mp) begin
            n_errors++;
            $display("FAIL br_alloc: pc=%h mp=%b expected pc=%h mp=%b", pc, mispredict, e.pc, e.mp);
        end
        redirect(16'h00FE, 16'h0020);
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 16'h1000) begin
            n_errors++;
            $display("FAIL br_stale_lookup: pt=%b tgt=%h expected pt=1 tgt=1000", pred_taken, pred_target);
        end
        drive_ex(1'b1, 16'h0020, 3'b111, 3'b000, 9'h000, 16'h1234, 1'b1, 16'h1000);
        #1;
        n_checks++;
        if (resolved_pc !== 16'h1234) begin
            n_errors++;
            $display("FAIL br_resolved_pc: got %h expected 1234", resolved_pc);
        end
        exp_q.push_back('{16'h1234, 1'b1});
        tick(); clear_ex();
        e = exp_q.pop_front();
        n_checks++;
        if (pc !== e.pc || mispredict !== e.mp) begin
            n_errors++;
            $display("FAIL br_target_miss: pc=%h mp=%b expected pc=%h mp=%b", pc, mispredict, e.pc, e.mp);
        end
        redirect(16'h00FE, 16'h0020);
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 16'h1234) begin
            n_errors++;
            $display("FAIL br_btb_updated: pt=%b tgt=%h expected pt=1 tgt=1234", pred_taken, pred_target);
        end
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1;
        drive_ex(1'b1, 16'h00FE, 3'b111, 3'b000, 9'h000, 16'h0040, 1'b0, 16'h0100);
        exp_q.push_back('{16'h0040, 1'b1});
        for (int i = 0; i < 3; i++) exp_q.push_back('{16'h0040, 1'b0});
        exp_q.push_back('{16'h0042, 1'b0});
        for (int i = 0; i < 5; i++) begin
            if (i == 4) stall = 1'b0;
            tick(); clear_ex();
            e = exp_q.pop_front();
            n_checks++;
            if (pc !== e.pc || mispredict !== e.mp) begin
                n_errors++;
                $display("FAIL stall_step%0d: pc=%h mp=%b expected pc=%h mp=%b",
                         i, pc, mispredict, e.pc, e.mp);
            end
        end
    endtask

    task automatic test_halt();
        // BTB still trains while halted: B at 0x0042, +16 halfwords -> 0x0064
        halt = 1'b1;
        drive_ex(1'b0, 16'h0042, 3'b111, 3'b000, 9'h010, 16'h0000, 1'b0, 16'h0064);
        for (int i = 0; i < 3; i++) exp_q.push_back('{16'h0042, 1'b0});
        for (int i = 0; i < 3; i++) begin
            tick(); clear_ex(); halt = 1'b0;
            e = exp_q.pop_front();
            n_checks++;
            if (pc !== e.pc || mispredict !== e.mp) begin
                n_errors++;
                $display("FAIL halt_step%0d: pc=%h mp=%b expected pc=%h mp=%b",
                         i, pc, mispredict, e.pc, e.mp);
            end
        end
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 16'h0064) begin
            n_errors++;
            $display("FAIL halt_btb_update: pt=%b tgt=%h expected pt=1 tgt=0064", pred_taken, pred_target);
        end
    endtask

    task automatic test_wrap_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        exp_q.push_back('{16'hFFFE, 1'b1});
        redirect(16'h0010, 16'hFFFE);
        e = exp_q.pop_front();
        n_checks++;
        if (pc !== e.pc || pred_taken !== 1'b0 || pred_target !== 16'h0000) begin
            n_errors++;
            $display("FAIL wrap_lookup: pc=%h pt=%b tgt=%h expected pc=%h pt=0 tgt=0000",
                     pc, pred_taken, pred_target, e.pc);
        end
        exp_q.push_back('{16'h0000, 1'b0});
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (pc !== e.pc || mispredict !== e.mp) begin
            n_errors++;
            $display("FAIL wrap_step: pc=%h mp=%b expected pc=%h mp=%b", pc, mispredict, e.pc, e.mp);
        end
        drive_ex(1'b1, 16'h0010, 3'b111, 3'b000, 9'h000, 16'h0800, 1'b0, 16'h0012);
        tick();
        drive_ex(1'b1, 16'h0010, 3'b111, 3'b000, 9'h000, 16'h0900, 1'b0, 16'h0012);
        rst = 1'b1;
        exp_q.push_back('{16'h0000, 1'b0});
        tick(); clear_ex(); rst = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (pc !== e.pc || mispredict !== e.mp) begin
            n_errors++;
            $display("FAIL reset_over_mp: pc=%h mp=%b expected pc=%h mp=%b", pc, mispredict, e.pc, e.mp);
        end
        redirect(16'h0032, 16'h0010);
        n_checks++;
        if (pc !== 16'h0010 || pred_taken !== 1'b0 || pred_target !== 16'h0012) begin
            n_errors++;
            $display("FAIL reset_btb_clear: pc=%h pt=%b tgt=%h expected 0010/0/0012",
                     pc, pred_taken, pred_target);
        end
    endtask

    initial begin
        test_reset();
        test_b_taken();
        test_loop_ctr();
        test_br_stale();
        test_stall_redirect();
        test_halt();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
